// File: rtl/turn_controller_pkg.sv
// Shared types and helpers for the game-turn sequencer.
package turn_ctrl_pkg;

  // Turn sequencer states; the encoding is fixed so that debug probes read consistently.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TURN_START = 3'd1,
    WAIT_MOVE  = 3'd2,
    VALIDATE   = 3'd3,
    COMMIT     = 3'd4,
    CHECK      = 3'd5,
    NEXT_TURN  = 3'd6,
    GAME_OVER  = 3'd7
  } state_t;

  // Bits needed to index n items; never returns less than 1.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Bundle of player, validator, checker and status signals around the turn sequencer.
interface turn_controller_if #(
  parameter int PW = 1,
  parameter int CW = 4
);
  logic          start;
  logic          move_ready;
  logic [CW-1:0] move_cell;
  logic [CW-1:0] rand_cell;
  logic          val_ack;
  logic          val_ok;
  logic          chk_ack;
  logic          chk_win;
  logic [PW-1:0] player;
  logic [CW-1:0] cell_out;
  logic          val_req;
  logic          commit;
  logic          chk_req;
  logic          random_used;
  logic          timeout;
  logic          game_over;
  logic [PW-1:0] winner;
  logic          tie;

  // The sequencer itself.
  modport slave (
    input  start, move_ready, move_cell, rand_cell, val_ack, val_ok, chk_ack, chk_win,
    output player, cell_out, val_req, commit, chk_req, random_used, timeout,
           game_over, winner, tie
  );

  // Everything around it: players, validator, win checker, display.
  modport master (
    output start, move_ready, move_cell, rand_cell, val_ack, val_ok, chk_ack, chk_win,
    input  player, cell_out, val_req, commit, chk_req, random_used, timeout,
           game_over, winner, tie
  );
endinterface

// File: rtl/turn_controller_timer.sv
// Per-turn down-counter: reloads to TURN_CYCLES-1, counts down while enabled, sticks at zero.
module turn_timer
  import turn_ctrl_pkg::*;
#(
  parameter int TURN_CYCLES = 50_000_000,
  parameter int TW          = width_of(TURN_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);
  localparam logic [TW-1:0] LOAD_VAL = TW'(TURN_CYCLES - 1);

  logic [TW-1:0] count;

  // Load has priority; decrement saturates so a stalled turn keeps reporting zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/turn_controller.sv
// Game-turn sequencer: turn order, per-turn timeout, random/probe moves,
// validator and win-checker handshakes, tie detection.
module turn_controller
  import turn_ctrl_pkg::*;
#(
  parameter int                      NUM_PLAYERS = 2,
  parameter int                      CELLS       = 9,
  parameter int                      TURN_CYCLES = 50_000_000,
  parameter logic [NUM_PLAYERS-1:0]  AUTO_MASK   = '0
) (
  input  logic               clk,
  input  logic               rst,
  turn_controller_if.slave   bus
);
  localparam int PW = width_of(NUM_PLAYERS);
  localparam int CW = width_of(CELLS);
  localparam int TW = width_of(TURN_CYCLES);
  localparam int MW = width_of(CELLS + 1);
  localparam int PN = 1 << PW;

  // Padded to a power of two so any player code indexes safely.
  localparam logic [PN-1:0] AUTO_EXT    = PN'(AUTO_MASK);
  localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);
  localparam logic [CW-1:0] LAST_CELL   = CW'(CELLS - 1);
  localparam logic [MW-1:0] ALL_CELLS   = MW'(CELLS);

  state_t        state;
  logic [MW-1:0] moves;
  logic          timer_zero;
  logic          timer_load;
  logic          timer_en;

  // The timer only runs in WAIT_MOVE, so it is frozen while a move is being validated.
  assign timer_load = (state == TURN_START);
  assign timer_en   = (state == WAIT_MOVE);

  turn_timer #(
    .TURN_CYCLES (TURN_CYCLES),
    .TW          (TW)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (timer_en),
    .zero (timer_zero)
  );

  // Turn FSM with all outputs registered; commit and timeout are single-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      moves           <= '0;
      bus.player      <= '0;
      bus.cell_out    <= '0;
      bus.val_req     <= 1'b0;
      bus.commit      <= 1'b0;
      bus.chk_req     <= 1'b0;
      bus.random_used <= 1'b0;
      bus.timeout     <= 1'b0;
      bus.game_over   <= 1'b0;
      bus.winner      <= '0;
      bus.tie         <= 1'b0;
    end else begin
      bus.commit  <= 1'b0;
      bus.timeout <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (bus.start) begin
            bus.player    <= '0;
            moves         <= '0;
            bus.winner    <= '0;
            bus.tie       <= 1'b0;
            bus.game_over <= 1'b0;
            state         <= TURN_START;
          end
        end
        TURN_START: begin
          bus.random_used <= 1'b0;
          state           <= WAIT_MOVE;
        end
        WAIT_MOVE: begin
          // Automatic players never wait; a real move beats a same-cycle expiry.
          if (AUTO_EXT[bus.player]) begin
            bus.cell_out    <= bus.rand_cell;
            bus.random_used <= 1'b1;
            bus.val_req     <= 1'b1;
            state           <= VALIDATE;
          end else if (bus.move_ready) begin
            bus.cell_out <= bus.move_cell;
            bus.val_req  <= 1'b1;
            state        <= VALIDATE;
          end else if (timer_zero) begin
            bus.timeout     <= 1'b1;
            bus.cell_out    <= bus.rand_cell;
            bus.random_used <= 1'b1;
            bus.val_req     <= 1'b1;
            state           <= VALIDATE;
          end
        end
        VALIDATE: begin
          if (!bus.val_req) begin
            // Re-request after the one idle cycle that separates probe attempts.
            bus.val_req <= 1'b1;
          end else if (bus.val_ack) begin
            bus.val_req <= 1'b0;
            if (bus.val_ok) begin
              bus.commit <= 1'b1;
              state      <= COMMIT;
            end else if (bus.random_used) begin
              // Linear probe with wrap; a free cell always exists while moves < CELLS.
              bus.cell_out <= (bus.cell_out == LAST_CELL) ? '0 : bus.cell_out + 1'b1;
            end else begin
              state <= WAIT_MOVE;
            end
          end
        end
        COMMIT: begin
          moves       <= moves + 1'b1;
          bus.chk_req <= 1'b1;
          state       <= CHECK;
        end
        CHECK: begin
          if (bus.chk_ack) begin
            bus.chk_req <= 1'b0;
            if (bus.chk_win) begin
              bus.winner    <= bus.player;
              bus.game_over <= 1'b1;
              state         <= GAME_OVER;
            end else if (moves == ALL_CELLS) begin
              bus.tie       <= 1'b1;
              bus.game_over <= 1'b1;
              state         <= GAME_OVER;
            end else begin
              state <= NEXT_TURN;
            end
          end
        end
        NEXT_TURN: begin
          bus.player <= (bus.player == LAST_PLAYER) ? '0 : bus.player + 1'b1;
          state      <= TURN_START;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/turn_controller.md
Name: turn_controller

Overview:
Parametrised game-turn sequencer for N-player, cell-board games such as tic-tac-toe. It sequences turns, runs a per-turn timeout, and substitutes a random move on timeout or for automatic players. It handshakes with an external move validator and an external win checker, and detects the full-board tie. It sits between player input logic, the board memory (via the commit strobe) and the display/win logic.

Parameters:
NUM_PLAYERS, 2, number of players; must be >= 2; players are numbered 0..NUM_PLAYERS-1.
CELLS, 9, number of board cells; the game ends as a tie after CELLS commits with no win.
TURN_CYCLES, 50_000_000, clock cycles allowed per turn before a random move is taken; must be >= 2.
AUTO_MASK, 0, NUM_PLAYERS-bit mask; bit p=1 makes player p automatic and it always plays the random source.
Derived widths: PW=$clog2(NUM_PLAYERS), CW=$clog2(CELLS), TW=$clog2(TURN_CYCLES).

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  start/restart request; sampled only in IDLE and GAME_OVER.
move_ready  in  1  current player has a move on move_cell; single-cycle or level.
move_cell  in  CW  cell index requested by the player.
rand_cell  in  CW  free-running random cell index.
val_ack  in  1  validator done; val_ok is valid in the same cycle.
val_ok  in  1  1 = the validated cell is free.
chk_ack  in  1  win checker done; chk_win is valid in the same cycle.
chk_win  in  1  1 = current player has won.
player  out  PW  player whose turn it is.
cell_out  out  CW  cell under validation or commit.
val_req  out  1  validation request; held until val_ack.
commit  out  1  one-cycle board write strobe for cell_out by player.
chk_req  out  1  win-check request; held until chk_ack.
random_used  out  1  the current move came from the random or probe path.
timeout  out  1  one-cycle pulse when the turn timer expires.
game_over  out  1  high while in GAME_OVER.
winner  out  PW  winning player; valid when game_over=1 and tie=0.
tie  out  1  board full with no winner; valid when game_over=1.

Behaviour:
- All outputs are registered. On reset: state=IDLE; all outputs 0; move counter and timer 0.
- Reset asserted mid-game aborts any handshake immediately. Validator and checker must tolerate a dropped req.
- IDLE: start=1 -> player=0, moves=0, winner/tie cleared -> TURN_START.
- TURN_START: load timer=TURN_CYCLES-1; random_used=0 -> WAIT_MOVE. Occupies one cycle.
- WAIT_MOVE: timer decrements by 1 per cycle, saturating at 0.
  - If AUTO_MASK[player]=1: latch rand_cell, random_used=1 -> VALIDATE on the first cycle.
  - Else if move_ready=1: latch move_cell -> VALIDATE.
  - Else if timer==0: pulse timeout, latch rand_cell, random_used=1 -> VALIDATE.
  - move_ready and timer==0 in the same cycle: the player move wins and no timeout pulse is issued.
- VALIDATE: val_req=1 with cell_out stable until val_ack. The timer is frozen while in VALIDATE.
  - ack with ok=1 -> COMMIT.
  - ack with ok=0 and random_used=0 -> WAIT_MOVE; the timer is not reloaded.
  - ack with ok=0 and random_used=1 -> probe: cell_out = (cell_out==CELLS-1) ? 0 : cell_out+1, stay in VALIDATE, and drop val_req for one cycle between requests.
  - The probe terminates because moves<CELLS guarantees a free cell.
- COMMIT: commit=1 for exactly one cycle; moves += 1 -> CHECK.
- CHECK: chk_req=1 until chk_ack.
  - chk_win=1 -> winner=player -> GAME_OVER. Win takes priority even on the final move.
  - Else moves==CELLS -> tie=1 -> GAME_OVER.
  - Else -> NEXT_TURN.
- NEXT_TURN: player = (player==NUM_PLAYERS-1) ? 0 : player+1 -> TURN_START.
- GAME_OVER: game_over=1, winner/tie held; start=1 -> same actions as IDLE+start, so game_over drops the next cycle.
- start in any other state is ignored.
- Latency, human move: move_ready to val_req = 1 cycle; val_ack(ok) to commit = 1 cycle; commit to chk_req = 1 cycle.

Decomposition:
- Package turn_ctrl_pkg: state_t enum (IDLE, TURN_START, WAIT_MOVE, VALIDATE, COMMIT, CHECK, NEXT_TURN, GAME_OVER) with explicit 3-bit encoding; a width helper function.
- Sub-module turn_timer: loadable down-counter with load, enable and zero flag, parametrised by TURN_CYCLES.
- FSM and datapath registers live in turn_controller.

Test Plan:
1. NUM_PLAYERS=2, CELLS=9, TURN_CYCLES=8. start, then P0 move_cell=4, val_ok=1, chk_win=0 -> commit with cell_out=4, player=0; next turn player=1.
2. No move_ready for 8 cycles -> timeout pulse on the cycle the timer reaches 0, random_used=1, cell_out=rand_cell (e.g. 3).
3. Random cell 8 rejected, then cell 0 accepted -> probe wraps 8 -> 0, val_req deasserts for 1 cycle between requests, commit cell_out=0.
4. Nine commits, no win -> tie=1, game_over=1. A win on the 9th commit -> tie=0, winner=current player.
5. NUM_PLAYERS=3, AUTO_MASK=3'b100 -> player sequence 0,1,2,0 with player 2 committing rand_cell without waiting; a start pulse in WAIT_MOVE is ignored.
6. Assert rst during VALIDATE -> all outputs 0 asynchronously, state IDLE; start restarts the game with player=0 and moves=0.
